// File: rtl/maxpool2x2_stream.sv
`default_nettype none
// ============================================================================
// Module      : maxpool2x2_stream
// Description : Streaming 2x2 / stride-2 signed max-pooling over a raster
//               feature map, valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module maxpool2x2_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] out_data,
    input  logic                         out_ready,
    output logic                         out_last
);

    localparam int c_CW   = $clog2(IMG_WIDTH);
    localparam int c_RW   = $clog2(IMG_HEIGHT);
    localparam int c_HALF = IMG_WIDTH / 2;
    localparam int c_IW   = (c_HALF > 1) ? $clog2(c_HALF) : 1;

    localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(IMG_WIDTH - 1);
    localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(IMG_HEIGHT - 1);

    logic [c_CW-1:0]              r_col;
    logic [c_RW-1:0]              r_row;
    logic signed [DATA_WIDTH-1:0] r_hreg;
    logic signed [DATA_WIDTH-1:0] r_linebuf [c_HALF];
    logic                         r_out_valid;
    logic signed [DATA_WIDTH-1:0] r_out_data;
    logic                         r_out_last;

    logic                         w_accept;
    logic [c_IW-1:0]              w_idx;
    logic signed [DATA_WIDTH-1:0] w_pmax;
    logic signed [DATA_WIDTH-1:0] w_lb;
    logic signed [DATA_WIDTH-1:0] w_wmax;
    logic                         w_win_done;
    logic                         w_frame_end;

    assign in_ready  = !r_out_valid || out_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

    assign w_accept    = in_valid && in_ready;
    assign w_idx       = c_IW'(r_col >> 1);
    assign w_win_done  = w_accept && r_col[0] && r_row[0];
    assign w_frame_end = (r_row == c_ROW_LAST) && (r_col == c_COL_LAST);

    always_comb begin
        w_lb   = r_linebuf[w_idx];
        w_pmax = (in_data > r_hreg) ? in_data : r_hreg;
        w_wmax = (w_pmax > w_lb) ? w_pmax : w_lb;
    end

    // Raster position and the even-column half of the horizontal pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col  <= '0;
            r_row  <= '0;
            r_hreg <= '0;
        end else if (w_accept) begin
            if (!r_col[0]) begin
                r_hreg <= in_data;
            end
            if (r_col == c_COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Top-row pair maxima wait here for the matching bottom row; no reset needed.
    always_ff @(posedge clk) begin
        if (w_accept && r_col[0] && !r_row[0]) begin
            r_linebuf[w_idx] <= w_pmax;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_win_done) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_wmax;
            r_out_last  <= w_frame_end;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

endmodule
`default_nettype wire
